// File: rtl/fetch_unit_pkg.sv
// Shared constants, entry type and credit helper for the RV32I instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC         = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;
    localparam int unsigned FETCH_FIFO_DEPTH = 2;
    localparam int unsigned CNT_W            = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // A new request may issue only while in-flight plus buffered words leave a free slot.
    function automatic logic credit_avail(input logic [CNT_W-1:0] out_cnt,
                                          input logic [CNT_W-1:0] fifo_cnt);
        logic [CNT_W:0] total;
        total = {1'b0, out_cnt} + {1'b0, fifo_cnt};
        return (total < (CNT_W + 1)'(FETCH_FIFO_DEPTH));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of {pc, inst} with push, pop, flush and occupancy count.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [FETCH_FIFO_DEPTH];
    fetch_entry_t     mem_d [FETCH_FIFO_DEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and count; flush wins over push and pop.
    always_comb begin
        do_pop_s  = pop && (count_q != 2'd0);
        do_push_s = push && ((count_q != CNT_W'(FETCH_FIFO_DEPTH)) || do_pop_s);
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit_checker.sv
// Structural invariants of the fetch stage, observed from the top-level state.
module fetch_unit_checker
    import fetch_unit_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic             imem_req,
    input logic             redirect,
    input logic [CNT_W-1:0] out_cnt,
    input logic [CNT_W-1:0] disc_cnt,
    input logic [CNT_W-1:0] fifo_cnt,
    input logic             id_valid,
    input logic [31:0]      id_inst
);

    logic [CNT_W:0] inflight_s;

    assign inflight_s = {1'b0, out_cnt} + {1'b0, fifo_cnt};

    a_credit: assert property (@(posedge clk) disable iff (rst)
        inflight_s <= (CNT_W + 1)'(FETCH_FIFO_DEPTH));

    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        disc_cnt <= out_cnt);

    a_no_req_on_redirect: assert property (@(posedge clk) disable iff (rst)
        redirect |-> !imem_req);

    a_bubble_is_nop: assert property (@(posedge clk) disable iff (rst)
        !id_valid |-> (id_inst == NOP_INST));

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, response buffering,
// IF/ID register with stall hold and redirect squash of wrong-path responses.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic [31:0]      id_pc_q, id_pc_d;

    logic             req_s, grant_s, resp_s, resp_drop_s, resp_keep_s;
    logic             accept_s, bypass_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    fetch_entry_t     fifo_head_s, resp_entry_s, pend_head_s, pend_push_s;
    logic [CNT_W-1:0] fifo_cnt_s, pend_cnt_s;
    logic             pend_unused_s;

    // Request credit, response classification and IF/ID source selection.
    always_comb begin
        req_s             = !rst && !redirect && credit_avail(out_cnt_q, fifo_cnt_s);
        grant_s           = req_s && imem_gnt;
        resp_s            = imem_rvalid && (out_cnt_q != 2'd0);
        resp_drop_s       = resp_s && (redirect || (disc_cnt_q != 2'd0));
        resp_keep_s       = resp_s && !resp_drop_s;
        fifo_empty_s      = (fifo_cnt_s == 2'd0);
        accept_s          = !id_stall || !id_valid_q;
        bypass_s          = resp_keep_s && fifo_empty_s && accept_s;
        fifo_pop_s        = !redirect && accept_s && !fifo_empty_s;
        fifo_push_s       = resp_keep_s && !bypass_s;
        resp_entry_s.pc   = pend_head_s.pc;
        resp_entry_s.inst = imem_rdata;
        pend_push_s.pc    = fetch_pc_q;
        pend_push_s.inst  = 32'h0000_0000;
    end

    // Next-state for PC, counters and the IF/ID register; redirect overrides everything.
    always_comb begin
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (grant_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        case ({grant_s, resp_s})
            2'b10:   out_cnt_d = out_cnt_q + 2'd1;
            2'b01:   out_cnt_d = out_cnt_q - 2'd1;
            default: out_cnt_d = out_cnt_q;
        endcase

        // Everything still in flight after a redirect cycle belongs to the wrong path.
        if (redirect) begin
            disc_cnt_d = out_cnt_q - {1'b0, resp_s};
        end else if (resp_s && (disc_cnt_q != 2'd0)) begin
            disc_cnt_d = disc_cnt_q - 2'd1;
        end else begin
            disc_cnt_d = disc_cnt_q;
        end

        if (redirect) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_pc_d    = id_pc_q;
        end else if (!accept_s) begin
            id_valid_d = id_valid_q;
            id_inst_d  = id_inst_q;
            id_pc_d    = id_pc_q;
        end else if (!fifo_empty_s) begin
            id_valid_d = 1'b1;
            id_inst_d  = fifo_head_s.inst;
            id_pc_d    = fifo_head_s.pc;
        end else if (bypass_s) begin
            id_valid_d = 1'b1;
            id_inst_d  = resp_entry_s.inst;
            id_pc_d    = resp_entry_s.pc;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_pc_d    = id_pc_q;
        end
    end

    // Stage state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= 32'h0000_0000;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    fetch_fifo u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (resp_entry_s),
        .pop       (fifo_pop_s),
        .flush     (redirect),
        .head      (fifo_head_s),
        .count     (fifo_cnt_s)
    );

    // PCs of granted requests, popped by every response whether kept or dropped.
    fetch_fifo u_pend_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_s),
        .push_data (pend_push_s),
        .pop       (resp_s),
        .flush     (1'b0),
        .head      (pend_head_s),
        .count     (pend_cnt_s)
    );

    assign pend_unused_s = ^{pend_head_s.inst, pend_cnt_s};

    fetch_unit_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .imem_req (req_s),
        .redirect (redirect),
        .out_cnt  (out_cnt_q),
        .disc_cnt (disc_cnt_q),
        .fifo_cnt (fifo_cnt_s),
        .id_valid (id_valid_q),
        .id_inst  (id_inst_q)
    );

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random grant/latency,
// and a reference of the expected program-order PC stream consumed by ID.
module tb_fetch_unit;

    localparam logic [31:0] EXP_NOP      = 32'h0000_0013;
    localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          gnt_pct = 100;
    int          dmin = 1;
    int          dmax = 1;
    mreq_t       mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic        last_req, last_gnt, last_rvalid;
    logic [31:0] last_addr;
    logic [31:0] next_pc;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: drive memory, sample outputs away from the edge, record ID consumption.
    task automatic cycle();
        mreq_t r;
        @(negedge clk);
        imem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        last_req    = imem_req;
        last_addr   = imem_addr;
        last_gnt    = imem_gnt;
        last_rvalid = imem_rvalid;
        if (!rst && id_valid && !id_stall && !redirect) begin
            got_pc.push_back(id_pc);
            got_inst.push_back(id_inst);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (last_rvalid) void'(mq.pop_front());
            if (last_req && last_gnt) begin
                r.addr = last_addr;
                r.due  = cyc + int'($urandom_range(dmax, dmin));
                mq.push_back(r);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_got();
        got_pc.delete();
        got_inst.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        checks++;
        if (last_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", last_req);
        else passes++;
        rst = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== EXP_NOP || id_pc !== 32'h0)
            $display("FAIL reset_outputs got v=%b inst=%h pc=%h exp v=0 inst=%h pc=0",
                     id_valid, id_inst, id_pc, EXP_NOP);
        else passes++;
    endtask

    task automatic test_stream();
        int exp_n;
        logic [31:0] e;
        gnt_pct = 100; dmin = 1; dmax = 1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_got();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 1) begin
                checks++;
                if (last_req !== 1'b1 || last_addr !== EXP_RESET_PC)
                    $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", last_req, last_addr, EXP_RESET_PC);
                else passes++;
            end
            exp_n = (k >= 3) ? k - 2 : 0;
            checks++;
            if (got_pc.size() != exp_n)
                $display("FAIL stream_timing cycle=%0d got=%0d exp=%0d", k, got_pc.size(), exp_n);
            else passes++;
        end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = EXP_RESET_PC + 32'(4 * i);
            checks++;
            if (got_pc[i] !== e || got_inst[i] !== mem_word(e))
                $display("FAIL stream_data idx=%0d got pc=%h inst=%h exp pc=%h inst=%h", i, got_pc[i], got_inst[i], e, mem_word(e));
            else passes++;
        end
        next_pc = EXP_RESET_PC + 32'(4 * got_pc.size());
    endtask

    task automatic test_stall();
        logic [31:0] h_pc, h_inst, e;
        int grants;
        clear_got();
        id_stall = 1'b1;
        h_pc = id_pc;
        h_inst = id_inst;
        checks++;
        if (id_valid !== 1'b1 || h_pc !== next_pc)
            $display("FAIL stall_entry got v=%b pc=%h exp v=1 pc=%h", id_valid, h_pc, next_pc);
        else passes++;
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (last_req && last_gnt) grants++;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== h_pc || id_inst !== h_inst)
                $display("FAIL stall_hold cycle=%0d got pc=%h inst=%h exp pc=%h inst=%h", k, id_pc, id_inst, h_pc, h_inst);
            else passes++;
        end
        checks++;
        if (last_req !== 1'b0) $display("FAIL stall_req_drop got=%b exp=0", last_req);
        else passes++;
        checks++;
        if (grants > 2) $display("FAIL stall_grants got=%0d exp<=2", grants);
        else passes++;
        id_stall = 1'b0;
        for (int k = 0; k < 20; k++) cycle();
        checks++;
        if (got_pc.size() < 15) $display("FAIL stall_release_count got=%0d exp>=15", got_pc.size());
        else passes++;
        for (int i = 0; i < got_pc.size(); i++) begin
            e = next_pc + 32'(4 * i);
            checks++;
            if (got_pc[i] !== e || got_inst[i] !== mem_word(e))
                $display("FAIL stall_data idx=%0d got pc=%h inst=%h exp pc=%h inst=%h", i, got_pc[i], got_inst[i], e, mem_word(e));
            else passes++;
        end
    endtask

    // Shared tail of the redirect scenarios: first request address and resumed stream.
    task automatic check_after_redirect(input logic [31:0] target, input int need, input string tag);
        logic seen;
        logic [31:0] first_addr, e;
        int n;
        seen = 1'b0;
        first_addr = 32'h0;
        n = 0;
        while (got_pc.size() < need && n < 60) begin
            cycle();
            if (!seen && last_req) begin
                seen = 1'b1;
                first_addr = last_addr;
            end
            n++;
        end
        checks++;
        if (!seen || first_addr !== target)
            $display("FAIL %s_first_req got seen=%b addr=%h exp addr=%h", tag, seen, first_addr, target);
        else passes++;
        checks++;
        if (got_pc.size() < need) $display("FAIL %s_count got=%0d exp>=%0d", tag, got_pc.size(), need);
        else passes++;
        for (int i = 0; i < got_pc.size(); i++) begin
            e = target + 32'(4 * i);
            checks++;
            if (got_pc[i] !== e || got_inst[i] !== mem_word(e))
                $display("FAIL %s_data idx=%0d got pc=%h inst=%h exp pc=%h inst=%h", tag, i, got_pc[i], got_inst[i], e, mem_word(e));
            else passes++;
        end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        gnt_pct = 100; dmin = 3; dmax = 3;
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (mq.size() != 2) $display("FAIL redir_outstanding_setup got=%0d exp=2", mq.size());
        else passes++;
        clear_got();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        checks++;
        if (last_req !== 1'b0) $display("FAIL redir_req_low got=%b exp=0", last_req);
        else passes++;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== EXP_NOP)
            $display("FAIL redir_squash got v=%b inst=%h exp v=0 inst=%h", id_valid, id_inst, EXP_NOP);
        else passes++;
        check_after_redirect(32'h0000_0100, 6, "redir_out");
    endtask

    task automatic test_redirect_rvalid_stall();
        int n;
        gnt_pct = 100; dmin = 1; dmax = 1;
        for (int k = 0; k < 4; k++) cycle();
        n = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc) && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (!(mq.size() > 0 && mq[0].due <= cyc)) $display("FAIL redir_rv_setup got pending=%0d exp>0", mq.size());
        else passes++;
        clear_got();
        redirect = 1'b1;
        id_stall = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        id_stall = 1'b0;
        checks++;
        if (last_req !== 1'b0) $display("FAIL redir_rv_req_low got=%b exp=0", last_req);
        else passes++;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== EXP_NOP)
            $display("FAIL redir_rv_squash got v=%b inst=%h exp v=0 inst=%h", id_valid, id_inst, EXP_NOP);
        else passes++;
        check_after_redirect(32'h0000_0200, 4, "redir_rv");
    endtask

    task automatic test_random_wrap();
        logic [31:0] e;
        gnt_pct = 60; dmin = 1; dmax = 3;
        clear_got();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        for (int k = 0; k < 200; k++) begin
            id_stall = (int'($urandom_range(99)) < 30);
            cycle();
        end
        id_stall = 1'b0;
        checks++;
        if (got_pc.size() < 20) $display("FAIL wrap_count got=%0d exp>=20", got_pc.size());
        else passes++;
        for (int i = 0; i < got_pc.size(); i++) begin
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            checks++;
            if (got_pc[i] !== e || got_inst[i] !== mem_word(e))
                $display("FAIL wrap_data idx=%0d got pc=%h inst=%h exp pc=%h inst=%h", i, got_pc[i], got_inst[i], e, mem_word(e));
            else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] e;
        for (int k = 0; k < 6; k++) begin
            id_stall = (int'($urandom_range(99)) < 50);
            cycle();
        end
        id_stall = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (last_req !== 1'b0) $display("FAIL midrst_req got=%b exp=0", last_req);
        else passes++;
        checks++;
        if (id_valid !== 1'b0 || id_inst !== EXP_NOP || id_pc !== 32'h0)
            $display("FAIL midrst_outputs got v=%b inst=%h pc=%h exp v=0 inst=%h pc=0", id_valid, id_inst, id_pc, EXP_NOP);
        else passes++;
        gnt_pct = 100; dmin = 1; dmax = 1;
        clear_got();
        cycle();
        checks++;
        if (last_req !== 1'b1 || last_addr !== EXP_RESET_PC)
            $display("FAIL midrst_first_req got req=%b addr=%h exp req=1 addr=%h", last_req, last_addr, EXP_RESET_PC);
        else passes++;
        for (int k = 0; k < 8; k++) cycle();
        checks++;
        if (got_pc.size() < 5) $display("FAIL midrst_count got=%0d exp>=5", got_pc.size());
        else passes++;
        for (int i = 0; i < got_pc.size(); i++) begin
            e = EXP_RESET_PC + 32'(4 * i);
            checks++;
            if (got_pc[i] !== e || got_inst[i] !== mem_word(e))
                $display("FAIL midrst_data idx=%0d got pc=%h inst=%h exp pc=%h inst=%h", i, got_pc[i], got_inst[i], e, mem_word(e));
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_stall = 1'b0;
        next_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_rvalid_stall();
        test_random_wrap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
